// File: rtl/soc_system_leds_pwm.sv
// soc_system_leds_pwm: Avalon-MM LED/GPIO output controller with per-channel
// blink, global PWM brightness and atomic set/clear registers.
// Optional build macro: LED_PWM_ACTIVE_LOW_EN (out_port and STATUS are
// inverted to pin level, reset value all ones).
module soc_system_leds_pwm #(
  parameter int unsigned WIDTH         = 5,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned PRESCALE_BITS = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  localparam int unsigned DUTY_W = PWM_BITS + 1;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_DUTY     = 3'd2;
  localparam logic [2:0] ADDR_PRESCALE = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  localparam logic [DUTY_W-1:0]   DUTY_FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;

`ifdef LED_PWM_ACTIVE_LOW_EN
  localparam logic [WIDTH-1:0] OUT_RST = '1;
`else
  localparam logic [WIDTH-1:0] OUT_RST = '0;
`endif

  logic [WIDTH-1:0]         data_q,      data_d;
  logic [WIDTH-1:0]         blink_en_q,  blink_en_d;
  logic [DUTY_W-1:0]        duty_q,      duty_d;
  logic [PRESCALE_BITS-1:0] prescale_q,  prescale_d;
  logic [PRESCALE_BITS-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]      pwm_cnt_q,   pwm_cnt_d;
  logic                     blink_phase_q, blink_phase_d;
  logic [WIDTH-1:0]         out_q,       out_d;

  logic             wr_en;
  logic             presc_wr;
  logic             tick;
  logic             pwm_on;
  logic [WIDTH-1:0] lit;
  logic             unused_wd;

  assign wr_en = chipselect & ~write_n;

  // Write data bits above each register's width are dropped on purpose.
  assign unused_wd = ^writedata;

  // Register file next-state: plain writes plus atomic set/clear on DATA.
  always_comb begin
    data_d     = data_q;
    blink_en_d = blink_en_q;
    duty_d     = duty_q;
    prescale_d = prescale_q;
    presc_wr   = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:     data_d     = writedata[WIDTH-1:0];
        ADDR_BLINK_EN: blink_en_d = writedata[WIDTH-1:0];
        ADDR_DUTY:     duty_d     = writedata[DUTY_W-1:0];
        ADDR_PRESCALE: begin
          prescale_d = writedata[PRESCALE_BITS-1:0];
          presc_wr   = 1'b1;
        end
        ADDR_OUTSET:   data_d     = data_q | writedata[WIDTH-1:0];
        ADDR_OUTCLR:   data_d     = data_q & ~writedata[WIDTH-1:0];
        default:       ;
      endcase
    end
  end

  // Timebase: prescaler tick drives the PWM counter; blink phase flips on PWM wrap.
  always_comb begin
    tick          = (presc_cnt_q == prescale_q);
    presc_cnt_d   = presc_cnt_q + PRESCALE_BITS'(1);
    pwm_cnt_d     = pwm_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
      if (pwm_cnt_q == PWM_MAX) begin
        blink_phase_d = ~blink_phase_q;
      end
    end
    if (presc_wr) begin
      presc_cnt_d = '0;
    end
  end

  // Output drive: data gated by PWM and, for blinking channels, by blink phase.
  always_comb begin
    pwm_on = duty_q[PWM_BITS] | (DUTY_W'(pwm_cnt_q) < duty_q);
    lit    = data_q & {WIDTH{pwm_on}} & (~blink_en_q | {WIDTH{blink_phase_q}});
`ifdef LED_PWM_ACTIVE_LOW_EN
    out_d  = ~lit;
`else
    out_d  = lit;
`endif
  end

  // Combinational read mux, zero-extended; write-only and reserved words read 0.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(data_q);
      ADDR_BLINK_EN: readdata = 32'(blink_en_q);
      ADDR_DUTY:     readdata = 32'(duty_q);
      ADDR_PRESCALE: readdata = 32'(prescale_q);
      ADDR_STATUS:   readdata = 32'(out_q);
      default:       readdata = '0;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q        <= '0;
      blink_en_q    <= '0;
      duty_q        <= DUTY_FULL;
      prescale_q    <= '0;
      presc_cnt_q   <= '0;
      pwm_cnt_q     <= '0;
      blink_phase_q <= 1'b1;
      out_q         <= OUT_RST;
    end else begin
      data_q        <= data_d;
      blink_en_q    <= blink_en_d;
      duty_q        <= duty_d;
      prescale_q    <= prescale_d;
      presc_cnt_q   <= presc_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      blink_phase_q <= blink_phase_d;
      out_q         <= out_d;
    end
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_soc_system_leds_pwm.sv
// Self-checking bench for soc_system_leds_pwm (WIDTH=5, PWM_BITS=4).
// Honours LED_PWM_ACTIVE_LOW_EN when the same macro is defined for the bench.
module tb_soc_system_leds_pwm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [4:0]  out_port;

  int n_total = 0;
  int n_pass  = 0;

  soc_system_leds_pwm #(
    .WIDTH(5),
    .PWM_BITS(4),
    .PRESCALE_BITS(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  always #5 clk = ~clk;

  // Logical LED value <-> pin level.
  function automatic logic [4:0] pin(input logic [4:0] v);
`ifdef LED_PWM_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Reference model: register contents plus a tick counter; PWM count and
  // blink phase are derived arithmetically from the number of ticks seen.
  logic [4:0] m_data, m_blink, m_out, m_lit;
  int         m_duty, m_presc, m_pos, m_ticks, m_pwm;
  bit         m_phase, m_on, m_tick;

  always begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_data = 5'd0; m_blink = 5'd0; m_duty = 16; m_presc = 0;
      m_pos = 0; m_ticks = 0; m_out = pin(5'd0);
    end else begin
      m_pwm   = m_ticks % 16;
      m_phase = ((m_ticks / 16) % 2) == 0;
      m_on    = (m_duty >= 16) || (m_pwm < m_duty);
      m_lit   = m_data & {5{m_on}} & (~m_blink | {5{m_phase}});
      m_out   = pin(m_lit);
      m_tick  = (m_pos == m_presc);
      if (m_tick) m_ticks = m_ticks + 1;
      if (m_tick) m_pos = 0; else m_pos = m_pos + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_data  = writedata[4:0];
          3'd1: m_blink = writedata[4:0];
          3'd2: m_duty  = int'(writedata[4:0]);
          3'd3: begin m_presc = int'(writedata[15:0]); m_pos = 0; end
          3'd4: m_data  = m_data | writedata[4:0];
          3'd5: m_data  = m_data & ~writedata[4:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return {27'd0, m_data};
      3'd1: return {27'd0, m_blink};
      3'd2: return 32'(m_duty);
      3'd3: return 32'(m_presc);
      3'd6: return {27'd0, m_out};
      default: return 32'd0;
    endcase
  endfunction

  // One bus write; returns 1 time unit after the edge that performs it.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom();
  endtask

  task automatic test_reset();
    logic [31:0] rst_vals [8];
    rst_vals = '{32'd0, 32'd0, 32'd16, 32'd0, 32'd0, 32'd0, {27'd0, pin(5'd0)}, 32'd0};
    #2;
    n_total++;
    if (out_port !== pin(5'd0)) $display("FAIL reset_out: got %h expected %h", out_port, pin(5'd0));
    else n_pass++;
    @(posedge clk); #1; reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      address = 3'(a); #1;
      n_total++;
      if (readdata !== rst_vals[a]) $display("FAIL reset_rd%0d: got %h expected %h", a, readdata, rst_vals[a]);
      else n_pass++;
    end
  endtask

  task automatic test_data();
    wr(3'd0, 32'h0000_0015);
    n_total++;
    if (out_port !== pin(5'd0)) $display("FAIL data_latency: got %h expected %h", out_port, pin(5'd0));
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (out_port !== pin(5'h15)) $display("FAIL data_out: got %h expected %h", out_port, pin(5'h15));
    else n_pass++;
    address = 3'd0; #1;
    n_total++;
    if (readdata !== 32'h0000_0015) $display("FAIL data_rd: got %h expected %h", readdata, 32'h15);
    else n_pass++;
  endtask

  task automatic test_setclr();
    wr(3'd0, 32'h1F);
    wr(3'd5, 32'h03);
    address = 3'd0; #1;
    n_total++;
    if (readdata !== 32'h1C) $display("FAIL outclr_rd: got %h expected %h", readdata, 32'h1C);
    else n_pass++;
    wr(3'd4, 32'hFFFF_FF01);
    address = 3'd0; #1;
    n_total++;
    if (readdata !== 32'h1D) $display("FAIL outset_rd: got %h expected %h", readdata, 32'h1D);
    else n_pass++;
    for (int a = 4; a < 6; a++) begin
      address = 3'(a); #1;
      n_total++;
      if (readdata !== 32'd0) $display("FAIL wo_rd%0d: got %h expected 0", a, readdata);
      else n_pass++;
    end
    @(posedge clk); #1;
    n_total++;
    if (out_port !== pin(5'h1D)) $display("FAIL setclr_out: got %h expected %h", out_port, pin(5'h1D));
    else n_pass++;
  endtask

  task automatic test_pwm();
    int duties [3];
    int want   [3];
    int ones;
    logic [4:0] lv;
    duties = '{4, 0, 16};
    want   = '{4, 0, 16};
    wr(3'd3, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1);
    for (int k = 0; k < 3; k++) begin
      wr(3'd2, 32'(duties[k]));
      @(posedge clk); #1;
      ones = 0;
      for (int i = 0; i < 16; i++) begin
        lv = pin(out_port);
        if (lv[0]) ones++;
        n_total++;
        if (out_port !== m_out) $display("FAIL pwm_model d=%0d c=%0d: got %h expected %h", duties[k], i, out_port, m_out);
        else n_pass++;
        @(posedge clk); #1;
      end
      n_total++;
      if (ones != want[k]) $display("FAIL pwm_count d=%0d: got %0d expected %0d", duties[k], ones, want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_blink();
    int changes, last_i, bad_iv, b0_low;
    logic prev;
    logic [4:0] lv;
    wr(3'd2, 32'd16);
    wr(3'd3, 32'd1);
    wr(3'd1, 32'd2);
    wr(3'd0, 32'd3);
    @(posedge clk); #1;
    lv = pin(out_port); prev = lv[1];
    changes = 0; last_i = -1; bad_iv = 0; b0_low = 0;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk); #1;
      lv = pin(out_port);
      if (!lv[0]) b0_low++;
      if (lv[1] != prev) begin
        if (last_i >= 0 && (i - last_i) != 32) bad_iv++;
        last_i = i; changes++;
        prev = lv[1];
      end
      n_total++;
      if (out_port !== m_out) $display("FAIL blink_model c=%0d: got %h expected %h", i, out_port, m_out);
      else n_pass++;
    end
    n_total++;
    if (b0_low != 0) $display("FAIL blink_bit0: got %0d low cycles expected 0", b0_low);
    else n_pass++;
    n_total++;
    if (changes < 4 || bad_iv != 0) $display("FAIL blink_period: got %0d toggles %0d bad intervals expected >=4 and 0", changes, bad_iv);
    else n_pass++;
  endtask

  task automatic test_prescale();
    int ones;
    logic [4:0] lv;
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd100);
    for (int i = 0; i < 37; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_port !== m_out) $display("FAIL presc_model_slow c=%0d: got %h expected %h", i, out_port, m_out);
      else n_pass++;
    end
    wr(3'd3, 32'd0);
    @(posedge clk); #1;
    ones = 0;
    for (int i = 0; i < 32; i++) begin
      lv = pin(out_port);
      if (lv[0]) ones++;
      n_total++;
      if (out_port !== m_out) $display("FAIL presc_model_fast c=%0d: got %h expected %h", i, out_port, m_out);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_total++;
    if (ones != 2) $display("FAIL presc_restart: got %0d pulses expected 2", ones);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] a;
    for (int i = 0; i < 400; i++) begin
      a = 3'($urandom_range(0, 7));
      address = a;
      chipselect = 1'($urandom_range(0, 1));
      write_n = 1'($urandom_range(0, 1));
      case (a)
        3'd2:    writedata = 32'($urandom_range(0, 20)) | ($urandom() & 32'hFFFF_FFE0);
        3'd3:    writedata = 32'($urandom_range(0, 3));
        default: writedata = $urandom();
      endcase
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
      n_total++;
      if (out_port !== m_out) $display("FAIL rand_out c=%0d: got %h expected %h", i, out_port, m_out);
      else n_pass++;
      address = 3'($urandom_range(0, 7)); #1;
      n_total++;
      if (readdata !== exp_rd(address)) $display("FAIL rand_rd c=%0d a=%0d: got %h expected %h", i, address, readdata, exp_rd(address));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    logic [2:0]  chk_a [5];
    logic [31:0] chk_v [5];
    chk_a = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    chk_v = '{32'd0, 32'd0, 32'd16, 32'd0, {27'd0, pin(5'd0)}};
    wr(3'd2, 32'd16);
    wr(3'd3, 32'd1);
    wr(3'd1, 32'h1F);
    wr(3'd0, 32'h1F);
    repeat (45) @(posedge clk);
    #3; reset_n = 1'b0;
    #1;
    n_total++;
    if (out_port !== pin(5'd0)) $display("FAIL areset_out: got %h expected %h", out_port, pin(5'd0));
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      address = chk_a[k]; #0.5;
      n_total++;
      if (readdata !== chk_v[k]) $display("FAIL areset_rd%0d: got %h expected %h", chk_a[k], readdata, chk_v[k]);
      else n_pass++;
    end
    @(posedge clk); #1; reset_n = 1'b1;
    wr(3'd1, 32'h0A);
    wr(3'd0, 32'h0F);
    wr(3'd2, 32'd9);
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      n_total++;
      if (out_port !== m_out) $display("FAIL areset_resume c=%0d: got %h expected %h", i, out_port, m_out);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_data();
    test_setclr();
    test_pwm();
    test_blink();
    test_prescale();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/soc_system_leds_pwm.md
Name: soc_system_leds_pwm

Overview:
Parametrised Avalon-MM LED/GPIO output controller. Successor to the fixed-width LED PIO.
- Adds per-channel blink, a global PWM brightness and atomic set/clear registers.
- Sits on the HPS lightweight bridge, drives board LEDs through out_port.
- With default registers it behaves as a plain PIO: full duty, no blink.

Parameters:
WIDTH, 5, channel count (1..32).
PWM_BITS, 8, PWM counter width (2..16).
PRESCALE_BITS, 16, prescaler width (1..31).

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  3  register word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data
readdata  output  32  combinational read data, zero-extended
out_port  output  WIDTH  registered LED drive

Behaviour:
Reset and clocking:
- One clock domain (clk).
- Reset is asynchronous, active-low (reset_n). It clears all state immediately.

Register map (write = chipselect & ~write_n):
- 0 DATA: rw, WIDTH bits. Reset 0.
- 1 BLINK_EN: rw, WIDTH bits. Reset 0.
- 2 DUTY: rw, PWM_BITS+1 bits. Reset 2^PWM_BITS (full on).
- 3 PRESCALE: rw, PRESCALE_BITS bits. Reset 0.
- 4 OUTSET: wo. DATA |= writedata[WIDTH-1:0]. Reads 0.
- 5 OUTCLR: wo. DATA &= ~writedata[WIDTH-1:0]. Reads 0.
- 6 STATUS: ro. Returns the current out_port. Writes are ignored.
- 7: reserved. Reads 0, writes ignored.
- writedata bits above a register's width are ignored. Read bits above it return 0.

Timebase:
- presc_cnt counts 0..PRESCALE. tick is asserted on the cycle presc_cnt == PRESCALE, then presc_cnt wraps to 0. PRESCALE=0 gives tick every cycle.
- A write to PRESCALE clears presc_cnt in the same edge.
- pwm_cnt (PWM_BITS) increments on tick and wraps from 2^PWM_BITS-1 to 0.
- blink_phase resets to 1. It toggles on the tick where pwm_cnt wraps.
- Blink period is 2*2^PWM_BITS*(PRESCALE+1) cycles.

PWM:
- pwm_on = (DUTY >= 2^PWM_BITS) | (pwm_cnt < DUTY).
- DUTY=0 is always off.
- A DUTY write takes effect on the next comparison. Counters are not reset.

Output:
- out_port[i] <= DATA[i] & pwm_on & (~BLINK_EN[i] | blink_phase). Registered.
- Latency: a register write at edge N is visible on out_port after edge N+1.
- Counters are free-running. No register write other than PRESCALE disturbs the counters.
- Reset asserted mid-operation: out_port = 0, counters = 0, blink_phase = 1 without waiting for clk.

Optional Feature:
LED_PWM_ACTIVE_LOW_EN
- Defined: out_port is the bitwise inverse of the value above. Reset value is all ones. STATUS returns the inverted (pin-level) value.
- Undefined: active-high as specified, reset 0.

Test Plan:
- Reset, then write DATA=0x15 at addr 0 -> out_port=0x15 one cycle after the write edge; readback addr 0 = 0x00000015.
- DATA=0x1F, then OUTCLR 0x03, then OUTSET 0x01 -> DATA reads 0x1C, then 0x1D; addr 4/5 read 0.
- PWM_BITS=4, PRESCALE=0, DUTY=4, DATA=0x01 -> out_port[0] high exactly 4 of every 16 cycles; DUTY=0 -> constant 0; DUTY=16 -> constant 1.
- PWM_BITS=4, PRESCALE=1, BLINK_EN=0x02, DATA=0x03, DUTY=16 -> bit0 steady 1; bit1 toggles every 32 cycles (period 64).
- Write PRESCALE=100 mid-count, then PRESCALE=0 -> the tick following the second write fires on the next cycle, not after the old count.
- Assert reset_n low asynchronously mid-blink -> out_port=0 before the next clk edge; all registers at reset values; STATUS=0. Repeat with LED_PWM_ACTIVE_LOW_EN defined -> out_port=all ones.
